instr_encoder: RTL

- Inverse of the instruction decode path: packs an instruction kind, 5-bit ALU control code, register indices, funct3 and a 32-bit immediate into an RV32I instruction word.
- Streams each word with a byte address into instruction-memory preload or self-test logic.
- Expands the LI pseudo-instruction into one or two words using a small FSM.
- Uses a valid/ready handshake on input and output.

---
 rtl/riscv_enc_pkg.sv | 82 ++++++++
 rtl/instr_pack.sv | 91 +++++++++
 rtl/instr_encoder.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/riscv_enc_pkg.sv
// ---------------------------------------------------------------------------
// riscv_enc_pkg
// Shared definitions for the RV32I instruction encoder: base opcodes (same
// values as the decoder's OP_* set), ALU control codes, request kinds, the
// LI expansion state type and small field-packing helpers for each format.
// ---------------------------------------------------------------------------
package riscv_enc_pkg;

    // Base opcodes
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // ALU control codes
    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b10000;
    localparam logic [4:0] ALU_SLL  = 5'b00100;
    localparam logic [4:0] ALU_SLT  = 5'b10111;
    localparam logic [4:0] ALU_SLTU = 5'b11000;
    localparam logic [4:0] ALU_XOR  = 5'b00011;
    localparam logic [4:0] ALU_SRL  = 5'b00101;
    localparam logic [4:0] ALU_SRA  = 5'b00110;
    localparam logic [4:0] ALU_OR   = 5'b00010;
    localparam logic [4:0] ALU_AND  = 5'b00001;

    // Request kinds; 10..15 are illegal
    localparam logic [3:0] KIND_R      = 4'd0;
    localparam logic [3:0] KIND_IALU   = 4'd1;
    localparam logic [3:0] KIND_LOAD   = 4'd2;
    localparam logic [3:0] KIND_STORE  = 4'd3;
    localparam logic [3:0] KIND_BRANCH = 4'd4;
    localparam logic [3:0] KIND_JAL    = 4'd5;
    localparam logic [3:0] KIND_JALR   = 4'd6;
    localparam logic [3:0] KIND_LUI    = 4'd7;
    localparam logic [3:0] KIND_AUIPC  = 4'd8;
    localparam logic [3:0] KIND_LI     = 4'd9;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EMIT_HI = 2'd1,
        EMIT_LO = 2'd2
    } enc_state_t;

    function automatic logic [31:0] enc_r(input logic [6:0] opcode, input logic [6:0] funct7,
                                          input logic [2:0] funct3, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2);
        return {funct7, rs2, rs1, funct3, rd, opcode};
    endfunction

    function automatic logic [31:0] enc_i(input logic [6:0] opcode, input logic [4:0] rd,
                                          input logic [2:0] funct3, input logic [4:0] rs1,
                                          input logic [11:0] imm12);
        return {imm12, rs1, funct3, rd, opcode};
    endfunction

    function automatic logic [31:0] enc_s(input logic [2:0] funct3, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [11:0] imm12);
        return {imm12[11:5], rs2, rs1, funct3, imm12[4:0], OP_STORE};
    endfunction

    // Branch offsets are even; bit 0 is not encoded
    function automatic logic [31:0] enc_b(input logic [2:0] funct3, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [12:1] off);
        return {off[12], off[10:5], rs2, rs1, funct3, off[4:1], off[11], OP_BRANCH};
    endfunction

    function automatic logic [31:0] enc_u(input logic [6:0] opcode, input logic [4:0] rd,
                                          input logic [19:0] imm20);
        return {imm20, rd, opcode};
    endfunction

    function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:1] off);
        return {off[20], off[10:1], off[11], off[19:12], rd, OP_JAL};
    endfunction

endpackage

// File: rtl/instr_pack.sv
// ---------------------------------------------------------------------------
// instr_pack
// Combinational packer: turns one request (kind, ALU code, register fields,
// funct3, immediate) into an RV32I word and flags requests that cannot be
// encoded. LI is packed as its short ADDI rd,x0,imm form; the top decides
// whether the two-word expansion is needed instead.
//
// Ports:
//   kind      in  4   request kind
//   alu_ctrl  in  5   ALU code (R and I-ALU)
//   funct3    in  3   funct3 for LOAD/STORE/BRANCH
//   rd,rs1,rs2 in 5   register indices
//   imm       in  32  immediate / offset
//   instr     out 32  encoded word
//   illegal   out 1   request cannot be encoded
// ---------------------------------------------------------------------------
module instr_pack
    import riscv_enc_pkg::*;
(
    input  logic [3:0]  kind,
    input  logic [4:0]  alu_ctrl,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic        illegal
);

    logic [6:0] alu_f7;
    logic [2:0] alu_f3;
    logic       alu_ok;
    logic       alu_shift;

    // ALU code to funct7/funct3; shifts take a 5-bit shamt in I-ALU form
    always_comb begin
        alu_f7    = 7'b0000000;
        alu_f3    = 3'b000;
        alu_ok    = 1'b1;
        alu_shift = 1'b0;
        case (alu_ctrl)
            ALU_ADD:  alu_f3 = 3'b000;
            ALU_SUB:  alu_f7 = 7'b0100000;
            ALU_SLL:  begin alu_f3 = 3'b001; alu_shift = 1'b1; end
            ALU_SLT:  alu_f3 = 3'b010;
            ALU_SLTU: alu_f3 = 3'b011;
            ALU_XOR:  alu_f3 = 3'b100;
            ALU_SRL:  begin alu_f3 = 3'b101; alu_shift = 1'b1; end
            ALU_SRA:  begin alu_f3 = 3'b101; alu_f7 = 7'b0100000; alu_shift = 1'b1; end
            ALU_OR:   alu_f3 = 3'b110;
            ALU_AND:  alu_f3 = 3'b111;
            default:  alu_ok = 1'b0;
        endcase
    end

    always_comb begin
        instr   = 32'h0;
        illegal = 1'b0;
        case (kind)
            KIND_R: begin
                instr   = enc_r(OP_R, alu_f7, alu_f3, rd, rs1, rs2);
                illegal = !alu_ok;
            end
            KIND_IALU: begin
                if (alu_shift)
                    instr = enc_i(OP_IMM, rd, alu_f3, rs1, {alu_f7, imm[4:0]});
                else
                    instr = enc_i(OP_IMM, rd, alu_f3, rs1, imm[11:0]);
                // There is no SUBI; negative ADDI covers it
                illegal = !alu_ok || (alu_ctrl == ALU_SUB);
            end
            KIND_LOAD:  instr = enc_i(OP_LOAD, rd, funct3, rs1, imm[11:0]);
            KIND_STORE: instr = enc_s(funct3, rs1, rs2, imm[11:0]);
            KIND_BRANCH: begin
                instr   = enc_b(funct3, rs1, rs2, imm[12:1]);
                illegal = imm[0];
            end
            KIND_JAL: begin
                instr   = enc_j(rd, imm[20:1]);
                illegal = imm[0];
            end
            KIND_JALR:  instr = enc_i(OP_JALR, rd, 3'b000, rs1, imm[11:0]);
            KIND_LUI:   instr = enc_u(OP_LUI, rd, imm[31:12]);
            KIND_AUIPC: instr = enc_u(OP_AUIPC, rd, imm[31:12]);
            KIND_LI:    instr = enc_i(OP_IMM, rd, 3'b000, 5'd0, imm[11:0]);
            default:    illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
// Streams encoded RV32I words with byte addresses. Requests are accepted on
// in_valid && in_ready and appear on the output register one cycle later.
// LI with an immediate outside 12-bit signed range expands to LUI + ADDI
// through a small FSM; illegal requests are consumed with a one-cycle err.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready request handshake
//   in_kind..in_imm   request fields
//   addr_clr          reload address to BASE_ADDR (ignored while out_valid)
//   out_valid/out_ready output handshake
//   out_instr         encoded word
//   out_addr          byte address of out_instr
//   err               one-cycle pulse after accepting an illegal request
// ---------------------------------------------------------------------------
module instr_encoder
    import riscv_enc_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_kind,
    input  logic [4:0]        in_alu_ctrl,
    input  logic [2:0]        in_funct3,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    input  logic              addr_clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err
);

    enc_state_t        state, state_next;
    logic              valid_next;
    logic [31:0]       instr_next;
    logic [ADDR_W-1:0] addr_next;
    logic              err_next;
    logic [4:0]        pend_rd, pend_rd_next;
    logic [11:0]       pend_lo, pend_lo_next;

    logic [31:0] pack_instr;
    logic        pack_illegal;
    logic        accept;
    logic        out_fire;
    logic        li_small;
    logic [19:0] li_hi;

    instr_pack u_pack (
        .kind     (in_kind),
        .alu_ctrl (in_alu_ctrl),
        .funct3   (in_funct3),
        .rd       (in_rd),
        .rs1      (in_rs1),
        .rs2      (in_rs2),
        .imm      (in_imm),
        .instr    (pack_instr),
        .illegal  (pack_illegal)
    );

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // Fits in a sign-extended 12-bit immediate when bits 31..11 all agree
    assign li_small = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
    // ADDI sign-extends its immediate, so the upper part rounds up when bit 11 is set
    assign li_hi    = in_imm[31:12] + 20'(in_imm[11]);

    // Next-state and next-output logic; everything holds unless an event moves it
    always_comb begin
        state_next   = state;
        valid_next   = out_valid;
        instr_next   = out_instr;
        addr_next    = out_addr;
        err_next     = 1'b0;
        pend_rd_next = pend_rd;
        pend_lo_next = pend_lo;

        // A clear can only land while no word is shown, so it never races an increment
        if (out_fire) begin
            addr_next  = out_addr + ADDR_W'(4);
            valid_next = 1'b0;
        end else if (addr_clr && !out_valid) begin
            addr_next = BASE_ADDR;
        end

        case (state)
            IDLE: begin
                if (accept) begin
                    if (pack_illegal) begin
                        err_next = 1'b1;
                    end else if (in_kind == KIND_LI && !li_small) begin
                        instr_next   = enc_u(OP_LUI, in_rd, li_hi);
                        valid_next   = 1'b1;
                        pend_rd_next = in_rd;
                        pend_lo_next = in_imm[11:0];
                        state_next   = EMIT_HI;
                    end else begin
                        instr_next = pack_instr;
                        valid_next = 1'b1;
                    end
                end
            end
            EMIT_HI: begin
                if (out_fire) begin
                    if (pend_lo != 12'h000) begin
                        instr_next = enc_i(OP_IMM, pend_rd, 3'b000, pend_rd, pend_lo);
                        valid_next = 1'b1;
                        state_next = EMIT_LO;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            EMIT_LO: begin
                if (out_fire)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State and output registers; reset discards any pending LI low word
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_instr <= 32'h0;
            out_addr  <= BASE_ADDR;
            err       <= 1'b0;
            pend_rd   <= 5'd0;
            pend_lo   <= 12'h000;
        end else begin
            state     <= state_next;
            out_valid <= valid_next;
            out_instr <= instr_next;
            out_addr  <= addr_next;
            err       <= err_next;
            pend_rd   <= pend_rd_next;
            pend_lo   <= pend_lo_next;
        end
    end

endmodule
